// File: rtl/spi_master_multi.sv
`default_nettype none
// ==========================================================================
// spi_master_multi : SPI master, runtime CPOL/CPHA, NUM_CS chip selects
// Rev 1.0
// ==========================================================================
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic [2:0]        i_cs_sel,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [NUM_CS-1:0] o_cs_n
);

  localparam int c_DIV_W  = $clog2(CLK_DIV + 1);
  localparam int c_EDGES  = 2 * DATA_W;
  localparam int c_EDGE_W = $clog2(c_EDGES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_EDGE_W-1:0] r_edge_cnt;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_dout;
  logic [2:0]          r_cs_sel;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_done;
  logic                r_err;
  logic                w_div_wrap;
  logic                w_accept;
  logic                w_reject;
  logic                w_edge;
  logic                w_finish;
  logic                w_leading;
  logic                w_sample;
  logic                w_shift;

  assign w_div_wrap = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
  // Edge numbers start at 1, so an even count of completed edges means the
  // next edge is a leading one.
  assign w_leading  = ~r_edge_cnt[0];
  assign w_sample   = w_edge & (w_leading ^ r_cpha);
  assign w_shift    = w_edge & ~(w_leading ^ r_cpha);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_edge      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (32'(i_cs_sel) < 32'(NUM_CS)) begin
            w_accept    = 1'b1;
            w_state_nxt = S_LEAD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_LEAD: begin
        if (w_div_wrap) begin
          w_edge      = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_div_wrap) begin
          if (r_edge_cnt == c_EDGE_W'(c_EDGES)) begin
            w_state_nxt = S_TRAIL;
          end else begin
            w_edge = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (w_div_wrap) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_dout     <= '0;
      r_cs_sel   <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_err  <= w_reject;
      if (w_accept) begin
        r_cpol     <= i_cpol;
        r_cpha     <= i_cpha;
        r_cs_sel   <= i_cs_sel;
        r_sclk     <= i_cpol;
        r_div_cnt  <= '0;
        r_edge_cnt <= '0;
        r_rx       <= '0;
        // With CPHA=0 the MSB must already be on the line before the first edge.
        if (i_cpha) begin
          r_tx   <= i_din;
          r_mosi <= 1'b0;
        end else begin
          r_tx   <= i_din << 1;
          r_mosi <= i_din[DATA_W-1];
        end
      end else if (r_state != S_IDLE) begin
        r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
        if (w_edge) begin
          r_sclk     <= ~r_sclk;
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
        if (w_sample) begin
          r_rx <= {r_rx[DATA_W-2:0], i_miso};
        end
        if (w_shift) begin
          r_mosi <= r_tx[DATA_W-1];
          r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
        end
        if (w_finish) begin
          r_dout <= r_rx;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign o_cs_n[gi] = ~((r_state != S_IDLE) && (r_cs_sel == 3'(gi)));
    end
  endgenerate

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;
  assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ==========================================================================
// tb_spi_master_multi : scoreboard bench for spi_master_multi (8- and 16-bit)
// Rev 1.0
// ==========================================================================
module tb_spi_master_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit instance, CLK_DIV=2, two chip selects
  logic       start8, cpol8, cpha8, miso8;
  logic [2:0] sel8;
  logic [7:0] din8, dout8;
  logic       busy8, done8, err8, sclk8, mosi8;
  logic [1:0] cs_n8;

  // 16-bit instance, CLK_DIV=1, loopback
  logic        start16, cpol16, cpha16;
  logic [2:0]  sel16;
  logic [15:0] din16, dout16;
  logic        busy16, done16, err16, sclk16, mosi16;
  logic [0:0]  cs_n16;

  logic       r_loop = 1'b1;
  logic       r_slv_miso = 1'b0;
  logic       slv_act = 1'b0;
  logic       slv_prev_sclk = 1'b0;
  logic       tb_cpol = 1'b0;
  logic       tb_cpha = 1'b0;
  logic [7:0] slv_word = '0;
  logic [7:0] slv_tx = '0;
  logic [7:0] slv_rx = '0;

  logic [7:0]  q8[$];
  logic [15:0] q16[$];

  int n_checks = 0;
  int n_errors = 0;

  assign miso8 = r_loop ? mosi8 : r_slv_miso;

  spi_master_multi #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2)) u_dut8 (
    .clk(clk), .reset(reset), .i_start(start8), .i_cpol(cpol8), .i_cpha(cpha8),
    .i_cs_sel(sel8), .i_din(din8), .o_dout(dout8), .o_busy(busy8), .o_done(done8),
    .o_err(err8), .o_sclk(sclk8), .o_mosi(mosi8), .i_miso(miso8), .o_cs_n(cs_n8)
  );

  spi_master_multi #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1)) u_dut16 (
    .clk(clk), .reset(reset), .i_start(start16), .i_cpol(cpol16), .i_cpha(cpha16),
    .i_cs_sel(sel16), .i_din(din16), .o_dout(dout16), .o_busy(busy16), .o_done(done16),
    .o_err(err16), .o_sclk(sclk16), .o_mosi(mosi16), .i_miso(mosi16), .o_cs_n(cs_n16)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
    end
  endtask

  // Slave device: shifts slv_word out on miso, captures mosi into slv_rx.
  always @(negedge clk) begin
    if (cs_n8 != 2'b11) begin
      if (!slv_act) begin
        slv_tx = slv_word;
        slv_rx = '0;
        if (!tb_cpha) begin
          r_slv_miso = slv_tx[7];
          slv_tx     = slv_tx << 1;
        end
      end else if (sclk8 != slv_prev_sclk) begin
        if ((sclk8 != tb_cpol) ^ tb_cpha) begin
          slv_rx = {slv_rx[6:0], mosi8};
        end else begin
          r_slv_miso = slv_tx[7];
          slv_tx     = slv_tx << 1;
        end
      end
      slv_act = 1'b1;
    end else begin
      slv_act = 1'b0;
    end
    slv_prev_sclk = sclk8;
  end

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && done8) begin
      chk("dout8_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) chk("dout8", 32'(dout8), 32'(q8.pop_front()));
    end
    if (reset && done16) begin
      chk("dout16_expected", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) chk("dout16", 32'(dout16), 32'(q16.pop_front()));
    end
  end

  task automatic run_xfer(input logic [7:0] din, input logic cpol, input logic cpha,
                          input logic [2:0] sel, input logic [7:0] slv, input logic loop,
                          input logic b2b, input logic mid_start);
    int         done_cyc, edges, cs_first, cs_last, errs;
    logic       prev_sclk;
    logic [1:0] exp_cs;
    // b2b: caller is at the negedge of the previous done cycle, which becomes cycle 0
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    tb_cpol  = cpol;
    tb_cpha  = cpha;
    slv_word = slv;
    r_loop   = loop;
    start8   = 1'b1;
    din8     = din;
    cpol8    = cpol;
    cpha8    = cpha;
    sel8     = sel;
    q8.push_back(loop ? din : slv);
    exp_cs         = 2'b11;
    exp_cs[sel[0]] = 1'b0;
    done_cyc = -1; edges = 0; cs_first = -1; cs_last = -1; errs = 0;
    prev_sclk = cpol;
    for (int n = 1; n <= 100 && done_cyc < 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start8 = 1'b0;
      if (mid_start && n == 10) begin
        start8 = 1'b1;
        din8   = ~din;
      end
      if (mid_start && n == 11) start8 = 1'b0;
      @(negedge clk);
      if (n > 1 && sclk8 != prev_sclk) edges++;
      prev_sclk = sclk8;
      if (cs_n8 == exp_cs) begin
        if (cs_first < 0) cs_first = n;
        cs_last = n;
      end
      errs += int'(err8);
      if (n == 1) begin
        chk("busy_c1", 32'(busy8), 32'd1);
        chk("cs_n_c1", 32'(cs_n8), 32'(exp_cs));
        chk("sclk_c1", 32'(sclk8), 32'(cpol));
        if (!cpha) chk("mosi_c1", 32'(mosi8), 32'(din[7]));
      end
      if (done8) begin
        done_cyc = n;
        chk("cs_n_at_done", 32'(cs_n8), 32'd3);
        chk("busy_at_done", 32'(busy8), 32'd0);
        chk("sclk_at_done", 32'(sclk8), 32'(cpol));
      end
    end
    chk("done_cycle", 32'(done_cyc), 32'd37);
    chk("cs_first", 32'(cs_first), 32'd1);
    chk("cs_last", 32'(cs_last), 32'd36);
    chk("sclk_edges", 32'(edges), 32'd16);
    chk("no_err", 32'(errs), 32'd0);
    if (!loop) chk("slave_rx", 32'(slv_rx), 32'(din));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, d16, e16;
    logic p16;
    reset = 1'b0;
    start8 = 1'b0; cpol8 = 1'b0; cpha8 = 1'b0; sel8 = '0; din8 = '0;
    start16 = 1'b0; cpol16 = 1'b0; cpha16 = 1'b0; sel16 = '0; din16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_cs_n", 32'(cs_n8), 32'd3);
    chk("rst_sclk", 32'(sclk8), 32'd0);
    chk("rst_mosi", 32'(mosi8), 32'd0);
    chk("rst_dout", 32'(dout8), 32'd0);
    chk("rst_done_err", 32'({done8, err8}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Mode 0 loopback
    run_xfer(8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Mode 3 against the slave model
    run_xfer(8'hAA, 1'b1, 1'b1, 3'd0, 8'hCC, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mode3_sclk_idle", 32'(sclk8), 32'd1);
    chk("dout_hold", 32'(dout8), 32'hCC);
    // Mode 2 slave, then back-to-back mode 1 on chip select 1
    run_xfer(8'hE4, 1'b1, 1'b0, 3'd0, 8'h71, 1'b0, 1'b0, 1'b0);
    run_xfer(8'h0F, 1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0);

    // Rejected start on an out-of-range chip select
    @(posedge clk);
    #1;
    start8 = 1'b1; sel8 = 3'd3;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    chk("err_c1", 32'(err8), 32'd1);
    chk("err_busy", 32'(busy8), 32'd0);
    chk("err_cs_n", 32'(cs_n8), 32'd3);
    @(negedge clk);
    chk("err_c2", 32'(err8), 32'd0);
    chk("err_c2_busy", 32'(busy8), 32'd0);

    // Start while busy must be ignored
    run_xfer(8'h96, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);

    // 16-bit loopback, CLK_DIV=1
    @(posedge clk);
    #1;
    start16 = 1'b1; din16 = 16'h1234;
    q16.push_back(16'h1234);
    d16 = -1; e16 = 0; p16 = 1'b0;
    for (int n = 1; n <= 100 && d16 < 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start16 = 1'b0;
      @(negedge clk);
      if (n > 1 && sclk16 != p16) e16++;
      p16 = sclk16;
      if (done16) d16 = n;
    end
    chk("d16_done_cycle", 32'(d16), 32'd35);
    chk("d16_edges", 32'(e16), 32'd32);

    // Reset in cycle 10 of a transfer aborts it
    @(posedge clk);
    #1;
    r_loop = 1'b1; tb_cpol = 1'b0; tb_cpha = 1'b0;
    start8 = 1'b1; din8 = 8'h5A; cpol8 = 1'b0; cpha8 = 1'b0; sel8 = 3'd0;
    dones = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start8 = 1'b0;
      if (n == 10) reset = 1'b0;
      @(negedge clk);
      dones += int'(done8);
    end
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n8), 32'd3);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_sclk", 32'(sclk8), 32'd0);
    chk("abort_mosi", 32'(mosi8), 32'd0);
    chk("abort_dout", 32'(dout8), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done8);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_xfer(8'h3C, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb8_drained", 32'(q8.size()), 32'd0);
    chk("sb16_drained", 32'(q16.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8, shift-word width in bits; legal range 2..32.
REQ-002 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range >= 1.
REQ-003 Parameter NUM_CS, default 2, number of chip-select lines; legal range 1..8.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-006 start  in  1  transfer request, sampled only in IDLE.
REQ-007 cpol  in  1  SCLK idle level, latched at accepted start.
REQ-008 cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accepted start.
REQ-009 cs_sel  in  3  target chip-select index, latched at accepted start.
REQ-010 din  in  DATA_W  word to transmit, MSB first, latched at accepted start.
REQ-011 dout  out  DATA_W  last received word.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle pulse at transfer completion.
REQ-014 err  out  1  one-cycle pulse on a rejected start.
REQ-015 sclk  out  1  serial clock.
REQ-016 mosi  out  1  serial data out.
REQ-017 miso  in  1  serial data in.
REQ-018 cs_n  out  NUM_CS  active-low chip selects, at most one low at a time.

Function
REQ-019 FSM states: IDLE, LEAD, XFER, TRAIL; every state transition occurs on a clk rising edge.
REQ-020 IDLE: busy=0, cs_n all 1, sclk=cpol of the last transfer (0 after reset).
REQ-021 start=1 in IDLE with cs_sel < NUM_CS (cycle 0): latch din/cpol/cpha/cs_sel; go to LEAD; from cycle 1, busy=1, cs_n[cs_sel]=0, sclk=cpol.
REQ-022 start=1 in IDLE with cs_sel >= NUM_CS: no transfer; err=1 in cycle 1; remain IDLE.
REQ-023 start while busy: ignored, with no effect on the transfer in progress and no err.
REQ-024 CPHA=0: first bit (din[DATA_W-1]) on mosi from cycle 1; miso sampled on each leading edge; mosi advances on each trailing edge.
REQ-025 CPHA=1: mosi advances on each leading edge (first bit appears on the first leading edge); miso sampled on each trailing edge.
REQ-026 LEAD lasts CLK_DIV cycles. XFER produces 2*DATA_W SCLK edges, each edge CLK_DIV cycles after the previous one (first edge at the end of LEAD). TRAIL lasts CLK_DIV cycles after the last edge.
REQ-027 At the end of TRAIL: cs_n all 1, dout = received word (first bit received = MSB), done=1 for one cycle, busy=0, return to IDLE. The done cycle is 1 + (2*DATA_W+2)*CLK_DIV cycles after cycle 0.
REQ-028 dout is updated only at done and holds its value otherwise.
REQ-029 sclk returns to cpol after the last edge and stays glitch-free (one toggle per edge event).
REQ-030 A new start is accepted in the done cycle itself (back-to-back transfers), with cs_n high for at least one cycle between transfers.

Reset
REQ-031 While reset=0 at a clk edge: state=IDLE, busy=0, done=0, err=0, cs_n all 1, sclk=0, mosi=0, dout=0, internal counters cleared.
REQ-032 Reset asserted mid-transfer aborts the transfer at the next clk edge: no done pulse, dout unchanged from its reset value.

Verification
REQ-033 DATA_W=8, CLK_DIV=2, mode 0, miso looped to mosi, din=8'hA5 -> done at cycle 37, dout=8'hA5, cs_n[0] low for cycles 1..36.
REQ-034 Mode 3 (cpol=1, cpha=1), slave model returns 8'hCC, din=8'hAA -> slave captures 8'hAA, dout=8'hCC, sclk idles high.
REQ-035 DATA_W=16, CLK_DIV=1, loopback, din=16'h1234 -> dout=16'h1234, exactly 32 sclk edges counted.
REQ-036 Second start pulse mid-transfer with different din -> ignored; single done pulse; dout reflects the first word only.
REQ-037 NUM_CS=2, cs_sel=3 -> err pulse in cycle 1, busy stays 0, cs_n=2'b11; cs_sel=1 -> only cs_n[1] goes low.
REQ-038 reset=0 at cycle 10 of a transfer -> next cycle cs_n all 1, busy=0, sclk=0, no done; a following transfer completes normally.
